cal_loader: RTL and testbench

CAL_LOADER -- requirements
Module: cal_loader

---
 rtl/cal_loader.sv | 115 +++++++++++
 tb/tb_cal_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_loader.sv
// Calibration coefficient loader: receives a checksummed byte-stream frame into a shadow
// bank and atomically commits it to the active bank that rd_data reads from.
module cal_loader #(
    parameter int unsigned W          = 16,
    parameter int unsigned N_CHANNELS = 8,
    parameter logic [7:0]  HEADER     = 8'hCA,
    localparam int unsigned N_ENTRIES = 2 * N_CHANNELS,
    localparam int unsigned AW        = $clog2(N_ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          in_byte,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                abort,
    input  logic [AW-1:0]       rd_addr,
    output logic signed [W-1:0] rd_data,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        StIdle,
        StDataHi,
        StDataLo,
        StCheck,
        StCommit
    } state_t;

    localparam logic [AW-1:0] LastIdx = AW'(N_ENTRIES - 1);
    localparam logic [W-1:0]  Unity   = W'(16'h0400);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q;
    logic [7:0]    sum_q;
    logic [7:0]    hi_q;
    logic          err_q;
    logic [W-1:0]  shadow_q [N_ENTRIES];
    logic [W-1:0]  active_q [N_ENTRIES];
    logic          accept;
    logic          take;

    assign in_ready = (state_q != StCommit);
    assign accept   = in_valid && in_ready;
    // A byte presented while abort is high is dropped, never interpreted.
    assign take     = accept && !abort;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StCommit);
    assign err      = err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (take && in_byte == HEADER) state_d = StDataHi;
            StDataHi: if (take) state_d = StDataLo;
            StDataLo: if (take) state_d = (idx_q == LastIdx) ? StCheck : StDataHi;
            StCheck:  if (take) state_d = (in_byte == sum_q) ? StCommit : StIdle;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // COMMIT always completes, even under abort.
        if (abort && state_q != StCommit) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            sum_q <= '0;
            hi_q  <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                active_q[i] <= i[0] ? Unity : '0;
            end
        end else begin
            err_q <= take && (state_q == StCheck) && (in_byte != sum_q);
            if (take) begin
                case (state_q)
                    StIdle: begin
                        if (in_byte == HEADER) begin
                            idx_q <= '0;
                            sum_q <= '0;
                        end
                    end
                    StDataHi: begin
                        hi_q  <= in_byte;
                        sum_q <= sum_q + in_byte;
                    end
                    StDataLo: begin
                        sum_q <= sum_q + in_byte;
                        idx_q <= idx_q + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (state_q == StCommit) active_q <= shadow_q;
        end
    end

    // Shadow contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (take && state_q == StDataLo) shadow_q[idx_q] <= W'({hi_q, in_byte});
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < N_ENTRIES) rd_data = active_q[rd_addr];
    end

endmodule

// File: tb/tb_cal_loader.sv
// Directed self-checking bench for cal_loader: reset state, commit, checksum error,
// garbage/gaps, abort, abort-during-commit and asynchronous reset mid-frame.
module tb_cal_loader;

    localparam logic [7:0] HDR = 8'hCA;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         in_byte;
    logic               in_valid;
    logic               in_ready;
    logic               abort;
    logic [3:0]         rd_addr;
    logic signed [15:0] rd_data;
    logic               busy, done, err;

    logic [3:0]         rd_addr5;
    logic signed [15:0] rd_data5;
    logic               in_ready5, busy5, done5, err5;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    cal_loader dut (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
        .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .err(err)
    );

    // Ten-entry instance so addresses 10..15 are out of range.
    cal_loader #(.N_CHANNELS(5)) dut5 (
        .clk(clk), .rst(rst), .in_byte(8'h00), .in_valid(1'b0), .in_ready(in_ready5),
        .abort(1'b0), .rd_addr(rd_addr5), .rd_data(rd_data5), .busy(busy5), .done(done5),
        .err(err5)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic send(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_byte  = HDR;
        repeat (n) @(negedge clk);
    endtask

    // Entry k = {hi, k}; checksum offset by adj; returns in the cycle after the checksum edge.
    task automatic send_frame(input logic [7:0] hi, input logic [7:0] adj, input bit gaps);
        logic [7:0] cs;
        cs = 8'h00;
        send(HDR);
        for (int k = 0; k < 16; k++) begin
            send(hi);
            cs = cs + hi;
            if (gaps && (k % 5 == 2)) idle(k % 3 + 1);
            send(8'(k));
            cs = cs + 8'(k);
            if (gaps && (k % 4 == 1)) idle(2);
        end
        send(cs + adj);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        rst = 1'b1; in_valid = 1'b0; abort = 1'b0; in_byte = 8'h00;
        rd_addr = 4'd0; rd_addr5 = 4'd0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            exp = (a % 2 == 1) ? 16'h0400 : 16'h0000;
            checks++;
            if (rd_data !== exp) begin
                errors++; $display("FAIL reset_entry[%0d]: got %h want %h", a, rd_data, exp);
            end
        end
        rd_addr5 = 4'd9; #1;
        checks++; if (rd_data5 !== 16'h0400) begin errors++; $display("FAIL n5_entry9: got %h want 0400", rd_data5); end
        rd_addr5 = 4'd10; #1;
        checks++; if (rd_data5 !== 16'h0000) begin errors++; $display("FAIL n5_oor10: got %h want 0000", rd_data5); end
        rd_addr5 = 4'd15; #1;
        checks++; if (rd_data5 !== 16'h0000) begin errors++; $display("FAIL n5_oor15: got %h want 0000", rd_data5); end
        @(negedge clk);
    endtask

    task automatic test_frame();
        int d0, e0;
        logic [15:0] exp;
        d0 = done_cnt; e0 = err_cnt; rd_addr = 4'd5;
        send_frame(8'h10, 8'h00, 1'b0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL frame_done_pulse: got %b want 1", done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL frame_commit_ready: got %b want 0", in_ready); end
        checks++; if (rd_data !== 16'h0400) begin errors++; $display("FAIL frame_early: got %h want 0400", rd_data); end
        @(negedge clk);
        checks++; if (rd_data !== 16'h1005) begin errors++; $display("FAIL frame_rd5: got %h want 1005", rd_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL frame_done_end: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy: got %b want 0", busy); end
        idle(2);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL frame_done_cnt: got %0d want 1", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL frame_err_cnt: got %0d want 0", err_cnt - e0); end
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            #1;
            exp = 16'h1000 + 16'(a);
            checks++;
            if (rd_data !== exp) begin
                errors++; $display("FAIL frame_entry[%0d]: got %h want %h", a, rd_data, exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_bad_checksum();
        int d0, e0;
        logic [15:0] exp;
        d0 = done_cnt; e0 = err_cnt; rd_addr = 4'd5;
        send_frame(8'h20, 8'h01, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err_pulse: got %b want 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_busy: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_end: got %b want 0", err); end
        idle(2);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL bad_err_cnt: got %0d want 1", err_cnt - e0); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL bad_done_cnt: got %0d want 0", done_cnt - d0); end
        for (int a = 0; a < 16; a += 5) begin
            rd_addr = 4'(a);
            #1;
            exp = 16'h1000 + 16'(a);
            checks++;
            if (rd_data !== exp) begin
                errors++; $display("FAIL bad_keep[%0d]: got %h want %h", a, rd_data, exp);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_garbage_gaps();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send(8'h00); send(8'hFF); send(8'h12);
        // High bytes equal HEADER, so the header value also appears as data.
        send_frame(HDR, 8'h00, 1'b1);
        idle(3);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL gap_done_cnt: got %0d want 1", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL gap_err_cnt: got %0d want 0", err_cnt - e0); end
        rd_addr = 4'd0; #1;
        checks++; if (rd_data !== 16'hCA00) begin errors++; $display("FAIL gap_rd0: got %h want CA00", rd_data); end
        rd_addr = 4'd5; #1;
        checks++; if (rd_data !== 16'hCA05) begin errors++; $display("FAIL gap_rd5: got %h want CA05", rd_data); end
        rd_addr = 4'd15; #1;
        checks++; if (rd_data !== 16'hCA0F) begin errors++; $display("FAIL gap_rd15: got %h want CA0F", rd_data); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt; rd_addr = 4'd5;
        send(HDR);
        for (int k = 0; k < 5; k++) begin
            send(8'h44);
            send(8'(k));
        end
        idle(30);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_hold_busy: got %b want 1", busy); end
        abort = 1'b1; in_byte = HDR; in_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (rd_data !== 16'hCA05) begin errors++; $display("FAIL abort_keep: got %h want CA05", rd_data); end
        send_frame(8'h55, 8'h00, 1'b0);
        idle(3);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL abort_done_cnt: got %0d want 1", done_cnt - d0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL abort_err_cnt: got %0d want 0", err_cnt - e0); end
        checks++; if (rd_data !== 16'h5505) begin errors++; $display("FAIL abort_rd5: got %h want 5505", rd_data); end
    endtask

    task automatic test_abort_commit();
        int d0;
        d0 = done_cnt; rd_addr = 4'd5;
        send_frame(8'h66, 8'h00, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (rd_data !== 16'h6605) begin errors++; $display("FAIL abcommit_rd5: got %h want 6605", rd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abcommit_busy: got %b want 0", busy); end
        idle(2);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL abcommit_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        rd_addr = 4'd1;
        send(HDR);
        send(8'h77);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (rd_data !== 16'h0400) begin errors++; $display("FAIL rstmid_rd1: got %h want 0400", rd_data); end
        rd_addr = 4'd4; #1;
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL rstmid_rd4: got %h want 0000", rd_data); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
        rd_addr = 4'd5;
        send_frame(8'h12, 8'h00, 1'b0);
        @(negedge clk);
        checks++; if (rd_data !== 16'h1205) begin errors++; $display("FAIL rstmid_recover: got %h want 1205", rd_data); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_bad_checksum();
        test_garbage_gaps();
        test_abort();
        test_abort_commit();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
